// File: rtl/arith_pkg.sv
// Shared arithmetic-unit package: operand width and the divider state encoding.
package arith_pkg;

  localparam int DATA_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WORK = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/divider_if.sv
// Divider issue/result bundle.
//
// Handshake: the master holds op_a_i/op_b_i and raises enable_i; the slave
// accepts only while idle (the accept cycle is the one where enable_i=1 and
// state_o==IDLE). busy_o is high while the quotient is being built. ready_o
// is a single-cycle pulse marking quotient_o/remainder_o/div_by_zero_o valid;
// those outputs then hold until the next ready_o pulse. enable_i outside IDLE
// is dropped, never queued.
interface divider_if
  import arith_pkg::*;
#(
  parameter int DATA_WIDTH = arith_pkg::DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] op_a_i;
  logic [DATA_WIDTH-1:0] op_b_i;
  logic                  enable_i;
  logic                  busy_o;
  logic                  ready_o;
  logic [DATA_WIDTH-1:0] quotient_o;
  logic [DATA_WIDTH-1:0] remainder_o;
  logic                  div_by_zero_o;
  div_state_t            state_o;

  modport slave (
    input  op_a_i, op_b_i, enable_i,
    output busy_o, ready_o, quotient_o, remainder_o, div_by_zero_o, state_o
  );

  modport master (
    output op_a_i, op_b_i, enable_i,
    input  busy_o, ready_o, quotient_o, remainder_o, div_by_zero_o, state_o
  );

endinterface

// File: rtl/divider_step.sv
// One restoring-division iteration: shift in the next dividend bit, try to
// subtract the divisor, keep the difference if it did not go negative.
module div_step
  import arith_pkg::*;
#(
  parameter int DATA_WIDTH = arith_pkg::DATA_WIDTH
) (
  input  logic [DATA_WIDTH:0]   rem_i,
  input  logic                  q_msb_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  output logic [DATA_WIDTH:0]   rem_o,
  output logic                  q_bit_o
);

  // The partial remainder is always below the divisor, so its top bit is
  // never set on entry; only the low DATA_WIDTH bits are shifted onward.
  logic                unused_rem_msb;
  logic [DATA_WIDTH:0] shifted;
  logic [DATA_WIDTH:0] trial;

  assign unused_rem_msb = rem_i[DATA_WIDTH];

  // Trial subtraction; a set MSB means the shifted remainder was too small.
  always_comb begin
    shifted = {rem_i[DATA_WIDTH-1:0], q_msb_i};
    trial   = shifted - {1'b0, divisor_i};
    q_bit_o = ~trial[DATA_WIDTH];
    rem_o   = trial[DATA_WIDTH] ? shifted : trial;
  end

endmodule

// File: rtl/divider.sv
// Iterative unsigned radix-2 restoring divider, one quotient bit per clock.
module divider
  import arith_pkg::*;
#(
  parameter int DATA_WIDTH = arith_pkg::DATA_WIDTH
) (
  input  logic      clk_i,
  input  logic      rsn_i,
  divider_if.slave  bus
);

  localparam int CW = $clog2(DATA_WIDTH);

  div_state_t            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH:0]   rem_q, rem_d;
  logic [DATA_WIDTH-1:0] q_q, q_d;
  logic [DATA_WIDTH-1:0] div_q, div_d;
  logic [DATA_WIDTH-1:0] quot_q, quot_d;
  logic [DATA_WIDTH-1:0] remo_q, remo_d;
  logic                  dbz_q, dbz_d;

  logic [DATA_WIDTH:0]   step_rem;
  logic                  step_bit;
  logic                  last_step;

  div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .rem_i     (rem_q),
    .q_msb_i   (q_q[DATA_WIDTH-1]),
    .divisor_i (div_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_bit)
  );

  assign last_step = (cnt_q == CW'(DATA_WIDTH - 1));

  // State, datapath and result registers; reset discards any in-flight work.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      div_q   <= '0;
      quot_q  <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      div_q   <= div_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next-state and datapath updates; results load only on entry to DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    q_d     = q_q;
    div_d   = div_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (bus.enable_i) begin
          q_d   = bus.op_a_i;
          div_d = bus.op_b_i;
          rem_d = '0;
          cnt_d = '0;
          if (bus.op_b_i == '0) begin
            // Divide by zero short-circuits straight to the result cycle.
            state_d = DONE;
            quot_d  = '1;
            remo_d  = bus.op_a_i;
            dbz_d   = 1'b1;
          end else begin
            state_d = WORK;
          end
        end
      end
      WORK: begin
        rem_d = step_rem;
        q_d   = {q_q[DATA_WIDTH-2:0], step_bit};
        cnt_d = cnt_q + 1'b1;
        if (last_step) begin
          state_d = DONE;
          quot_d  = {q_q[DATA_WIDTH-2:0], step_bit};
          remo_d  = step_rem[DATA_WIDTH-1:0];
          dbz_d   = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decodes of registered state only.
  always_comb begin
    bus.busy_o        = (state_q == WORK);
    bus.ready_o       = (state_q == DONE);
    bus.quotient_o    = quot_q;
    bus.remainder_o   = remo_q;
    bus.div_by_zero_o = dbz_q;
    bus.state_o       = state_q;
  end

endmodule

// File: doc/divider.md
# divider

Iterative unsigned radix-2 restoring divider, the inverse operation to the team's `multiplier`. It shares that block's operand width and its `enable_i`/`ready_o` handshake, so both sit side by side behind the same arithmetic-unit issue logic. It computes quotient and remainder of two DATA_WIDTH-bit unsigned operands, one quotient bit per clock, and flags division by zero.

## Interface
- DATA_WIDTH, 64, operand/result width (shared package constant, overridable)
- clk_i  in  1  clock, rising edge
- rsn_i  in  1  reset, asynchronous, active-low
- op_a_i  in  DATA_WIDTH  dividend, sampled on accept
- op_b_i  in  DATA_WIDTH  divisor, sampled on accept
- enable_i  in  1  start request, accepted only in IDLE
- busy_o  out  1  high while a division is in progress (WORK)
- ready_o  out  1  one-cycle pulse: results valid
- quotient_o  out  DATA_WIDTH  quotient
- remainder_o  out  DATA_WIDTH  remainder
- div_by_zero_o  out  1  set with ready_o when divisor was 0

## Operation
- States: IDLE, WORK, DONE (enum in package)
- IDLE: on enable_i=1 latch op_a_i into quotient shift register, op_b_i into divisor register; clear partial remainder (DATA_WIDTH+1 bits) and step counter; go WORK. If op_b_i==0 go DONE directly.
- WORK, per cycle: trial = {rem[DATA_WIDTH-1:0], q[DATA_WIDTH-1]} - {1'b0, divisor}; if trial MSB=0 then rem=trial, shift 1 into q LSB; else rem={rem[DATA_WIDTH-1:0], q[DATA_WIDTH-1]}, shift 0 into q LSB. Counter increments; after step DATA_WIDTH-1 go DONE.
- DONE: ready_o=1 for exactly this cycle; return to IDLE unconditionally.
- Outputs quotient_o/remainder_o/div_by_zero_o are registered, loaded on the WORK->DONE or IDLE->DONE transition, and held stable until the next DONE.
- Divide by zero: quotient_o = all ones, remainder_o = dividend, div_by_zero_o=1. Otherwise div_by_zero_o=0.
- enable_i while WORK or DONE: ignored, no queueing; operand changes during WORK have no effect.

## Timing
- Accept in cycle 0 (IDLE, enable_i=1) -> busy_o high cycles 1..DATA_WIDTH -> ready_o high in cycle DATA_WIDTH+1 (65 at default). Next accept possible in cycle DATA_WIDTH+2.
- Divisor zero: ready_o high in cycle 1, busy_o never asserted.
- Throughput: one division per DATA_WIDTH+2 cycles.
- Reset (rsn_i low, any time, including mid-WORK): immediately state=IDLE; busy_o=0, ready_o=0, quotient_o=0, remainder_o=0, div_by_zero_o=0, internal registers cleared; in-flight operation is discarded and no ready_o is produced for it.
- All outputs are driven from flops; no combinational path from inputs to outputs.

## Structure
- Shared package `arith_pkg`: DATA_WIDTH localparam, state enum `div_state_t` {IDLE, WORK, DONE}; `multiplier` imports the same width constant.
- Sub-module `div_step`: purely combinational single iteration (inputs rem, q MSB, divisor; outputs next rem, quotient bit). This keeps the top block to the FSM, counter and registers, and makes a future unrolled radix-4 variant a two-instance change.
- Counter width $clog2(DATA_WIDTH).

## Test plan
- 100 / 7 -> ready_o in cycle 65, quotient_o=14, remainder_o=2, div_by_zero_o=0.
- 5 / 0 -> ready_o in cycle 1, quotient_o=64'hFFFF_FFFF_FFFF_FFFF, remainder_o=5, div_by_zero_o=1, busy_o never high.
- 64'hFFFF_FFFF_FFFF_FFFF / 1 -> quotient all ones, remainder 0; 3 / 10 -> quotient 0, remainder 3.
- Start 1000/3, toggle enable_i and change operands during WORK -> single ready_o pulse, quotient 333, remainder 1; outputs stable until next DONE.
- Assert rsn_i low at cycle 30 of a division -> all outputs 0 at once, no ready_o; a new 81/9 issued after reset gives quotient 9, remainder 0.
- Random 10k operand pairs vs. reference model (a/b, a%b) -> all match, ready_o exactly once per accept.
